// File: rtl/memory_read_arbiter_rr.sv
// memory_read_arbiter_rr: N-way read-port arbiter (optional port-0 priority + round-robin) with in-flight response routing
// Ports: req_valid/req_addr/req_ready/rsp_valid/rsp_data face the requesters; mem_valid/mem_addr/mem_ready/mem_data face memory;
//        clear_counters/stall_cycles expose a saturating contention counter; last_grant is the most recently accepted port.
module memory_read_arbiter_rr #(
  parameter int N_REQ             = 4,
  parameter int REQ_ID_BITS       = 2,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEM_LATENCY       = 1,
  parameter int PRIO0             = 1,
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]                   req_ready,
  output logic [N_REQ-1:0]                   rsp_valid,
  output logic [MEMORY_WIDTH-1:0]            rsp_data,
  output logic                               mem_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr,
  input  logic                               mem_ready,
  input  logic [MEMORY_WIDTH-1:0]            mem_data,
  input  logic                               clear_counters,
  output logic [STALL_COUNT_WIDTH-1:0]       stall_cycles,
  output logic [REQ_ID_BITS-1:0]             last_grant
);
  logic [REQ_ID_BITS-1:0]       rr_q, rr_d, lg_q, g;
  logic [STALL_COUNT_WIDTH-1:0] stall_q, stall_d;
  logic                         prio_hit, hs;
  function automatic int wrap(input int x);
    return x >= N_REQ ? x - N_REQ : x;
  endfunction
  assign prio_hit = (PRIO0 != 0) && req_valid[0];
  // Scan from the far end so the candidate closest to rr_q is written last and wins.
  always_comb begin
    g = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[wrap(int'(rr_q) + k)] && !((PRIO0 != 0) && wrap(int'(rr_q) + k) == 0))
        g = REQ_ID_BITS'(wrap(int'(rr_q) + k));
    if (prio_hit) g = '0;
  end
  assign mem_valid    = |req_valid;
  assign mem_addr     = mem_valid ? req_addr[int'(g)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH] : '0;
  // No request is accepted while in reset, so nothing from the reset cycle can produce a response.
  assign hs           = mem_valid & mem_ready & ~rst;
  assign req_ready    = hs ? N_REQ'(1) << g : '0;
  assign rsp_data     = mem_data;
  assign stall_cycles = stall_q;
  assign last_grant   = lg_q;
  always_comb begin
    rr_d    = (hs && !prio_hit) ? ((int'(g) == N_REQ - 1) ? '0 : g + 1'b1) : rr_q;
    stall_d = clear_counters ? '0 : (mem_valid && !mem_ready && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= '0;
      lg_q    <= '0;
      stall_q <= '0;
    end else begin
      rr_q    <= rr_d;
      lg_q    <= hs ? g : lg_q;
      stall_q <= stall_d;
    end
  end
  generate
    if (MEM_LATENCY == 0) begin : g_nolat
      assign rsp_valid = req_ready;
    end else begin : g_pipe
      logic [MEM_LATENCY-1:0] v_q;
      logic [REQ_ID_BITS-1:0] id_q [MEM_LATENCY];
      always_ff @(posedge clk) begin
        v_q[0]  <= rst ? 1'b0 : hs;
        id_q[0] <= g;
        for (int k = 1; k < MEM_LATENCY; k++) begin
          v_q[k]  <= rst ? 1'b0 : v_q[k-1];
          id_q[k] <= id_q[k-1];
        end
      end
      assign rsp_valid = v_q[MEM_LATENCY-1] ? N_REQ'(1) << id_q[MEM_LATENCY-1] : '0;
    end
  endgenerate
endmodule

// File: tb/tb_memory_read_arbiter_rr.sv
// tb_memory_read_arbiter_rr: table, directed and randomized checks of memory_read_arbiter_rr
module tb_memory_read_arbiter_rr;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail  = 0;
  logic        rst_a, mv_a, mr_a, clr_a;
  logic [3:0]  rv_a, rdy_a, rsp_a;
  logic [43:0] ra_a;
  logic [15:0] rd_a, md_a, st_a;
  logic [10:0] ma_a;
  logic [1:0]  lg_a;
  logic        rst_b, mv_b, mr_b, clr_b;
  logic [2:0]  rv_b, rdy_b, rsp_b;
  logic [32:0] ra_b;
  logic [15:0] rd_b, md_b;
  logic [10:0] ma_b;
  logic [3:0]  st_b;
  logic [1:0]  lg_b;
  memory_read_arbiter_rr #(.N_REQ(4), .REQ_ID_BITS(2), .MEM_LATENCY(1), .PRIO0(1), .STALL_COUNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(rv_a), .req_addr(ra_a), .req_ready(rdy_a), .rsp_valid(rsp_a),
    .rsp_data(rd_a), .mem_valid(mv_a), .mem_addr(ma_a), .mem_ready(mr_a), .mem_data(md_a),
    .clear_counters(clr_a), .stall_cycles(st_a), .last_grant(lg_a));
  memory_read_arbiter_rr #(.N_REQ(3), .REQ_ID_BITS(2), .MEM_LATENCY(3), .PRIO0(0), .STALL_COUNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(rv_b), .req_addr(ra_b), .req_ready(rdy_b), .rsp_valid(rsp_b),
    .rsp_data(rd_b), .mem_valid(mv_b), .mem_addr(ma_b), .mem_ready(mr_b), .mem_data(md_b),
    .clear_counters(clr_b), .stall_cycles(st_b), .last_grant(lg_b));
  typedef struct {
    logic [3:0]  v;
    logic        mr;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
    logic [10:0] addr;
    int          lg;
    int          st;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pick(input int v, input int ptr, input int prio, input int n);
    if (prio != 0 && v[0]) return 0;
    for (int k = 0; k < n; k++) begin
      int i;
      i = (ptr + k) % n;
      if (!(prio != 0 && i == 0) && v[i]) return i;
    end
    return -1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  int addr_a[4];
  int ptr, last, stall, g, rsp_id;
  int pipe[$];
  logic [3:0] v;
  bit mr, clr, hs;
  initial begin
    tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 11'h000, 0, 0};
    tbl[1]  = '{4'b1110, 1'b1, 4'b0010, 4'b0000, 11'h011, 0, 0};
    tbl[2]  = '{4'b1110, 1'b1, 4'b0100, 4'b0010, 11'h022, 1, 0};
    tbl[3]  = '{4'b1110, 1'b1, 4'b1000, 4'b0100, 11'h033, 2, 0};
    tbl[4]  = '{4'b1110, 1'b1, 4'b0010, 4'b1000, 11'h011, 3, 0};
    tbl[5]  = '{4'b0111, 1'b1, 4'b0001, 4'b0010, 11'h0AA, 1, 0};
    tbl[6]  = '{4'b0111, 1'b1, 4'b0001, 4'b0001, 11'h0AA, 0, 0};
    tbl[7]  = '{4'b0110, 1'b1, 4'b0100, 4'b0001, 11'h022, 0, 0};
    tbl[8]  = '{4'b1100, 1'b0, 4'b0000, 4'b0100, 11'h033, 2, 0};
    tbl[9]  = '{4'b1100, 1'b0, 4'b0000, 4'b0000, 11'h033, 2, 1};
    tbl[10] = '{4'b1100, 1'b1, 4'b1000, 4'b0000, 11'h033, 2, 2};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 4'b1000, 11'h000, 3, 2};
    ra_a = {11'h033, 11'h022, 11'h011, 11'h0AA};
    ra_b = {11'h303, 11'h202, 11'h101};
    rv_a = '0; mr_a = 1'b1; clr_a = 1'b0; md_a = '0;
    rv_b = '0; mr_b = 1'b1; clr_b = 1'b0; md_b = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    // Table: reset state, round-robin order, port-0 priority, stalls
    for (int r = 0; r < 12; r++) begin
      rv_a = tbl[r].v;
      mr_a = tbl[r].mr;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), int'(rdy_a), int'(tbl[r].rdy));
      chk($sformatf("tbl%0d_rsp", r), int'(rsp_a), int'(tbl[r].rsp));
      chk($sformatf("tbl%0d_addr", r), int'(ma_a), int'(tbl[r].addr));
      chk($sformatf("tbl%0d_mvalid", r), int'(mv_a), int'(|tbl[r].v));
      chk($sformatf("tbl%0d_lastg", r), int'(lg_a), tbl[r].lg);
      chk($sformatf("tbl%0d_stall", r), int'(st_a), tbl[r].st);
      tick();
    end
    // Five stall cycles with ports 2,3 waiting, then accept; then clear during a stall
    rst_a = 1'b1; rv_a = '0; tick(); rst_a = 1'b0;
    rv_a = 4'b1100; mr_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_addr", int'(ma_a), 'h022);
      chk("stall_noready", int'(rdy_a), 0);
      tick();
    end
    mr_a = 1'b1;
    @(negedge clk);
    chk("stall_first_grant", int'(rdy_a), 'b0100);
    chk("stall_count5", int'(st_a), 5);
    tick();
    mr_a = 1'b0; clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    @(negedge clk);
    chk("clear_wins", int'(st_a), 0);
    tick();
    @(negedge clk);
    chk("count_after_clear", int'(st_a), 1);
    tick();
    // N_REQ=3, PRIO0=0, latency 3: order 0,1,2,0,... with responses trailing by 3
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    rv_b = 3'b111; mr_b = 1'b1;
    for (int c = 0; c < 7; c++) begin
      md_b = 16'(c * 7 + 1);
      @(negedge clk);
      chk("b_order", int'(rdy_b), 1 << (c % 3));
      chk("b_rsp", int'(rsp_b), c >= 3 ? 1 << ((c - 3) % 3) : 0);
      chk("b_lastg", int'(lg_b), c == 0 ? 0 : (c - 1) % 3);
      chk("b_rdata", int'(rd_b), c * 7 + 1);
      tick();
    end
    // Reset one cycle after the 2nd grant: in-flight reads are dropped
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("b_pre_rst_grant", int'(rdy_b), 1 << c);
      tick();
    end
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_no_ready_in_rst", int'(rdy_b), 0);
    tick();
    rst_b = 1'b0; mr_b = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("b_no_rsp_after_rst", int'(rsp_b), 0);
      tick();
    end
    @(negedge clk);
    chk("b_lastg_reset", int'(lg_b), 0);
    tick();
    mr_b = 1'b1;
    @(negedge clk);
    chk("b_post_rst_grant", int'(rdy_b), 1);
    tick();
    // Saturation of the 4-bit counter
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    rv_b = 3'b001; mr_b = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("b_sat", int'(st_b), c < 15 ? c : 15);
      tick();
    end
    // Randomized run against a reference model
    rst_a = 1'b1; rv_a = '0; clr_a = 1'b0; tick(); rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = int'($urandom_range(0, 2047));
      ra_a[i*11 +: 11] = 11'(addr_a[i]);
    end
    ptr = 0; last = 0; stall = 0;
    pipe = {-1};
    for (int c = 0; c < 400; c++) begin
      v = 4'($urandom_range(0, 15));
      mr = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rv_a = v; mr_a = mr; clr_a = clr; md_a = 16'($urandom);
      g = pick(int'(v), ptr, 1, 4);
      hs = (g >= 0) && mr;
      rsp_id = pipe[0];
      @(negedge clk);
      chk("rand_ready", int'(rdy_a), hs ? 1 << g : 0);
      chk("rand_rsp", int'(rsp_a), rsp_id >= 0 ? 1 << rsp_id : 0);
      chk("rand_addr", int'(ma_a), g >= 0 ? addr_a[g] : 0);
      chk("rand_lastg", int'(lg_a), last);
      chk("rand_stall", int'(st_a), stall);
      chk("rand_rdata", int'(rd_a), int'(md_a));
      if (hs) begin
        last = g;
        if (!v[0]) ptr = (g + 1) % 4;
      end
      stall = clr ? 0 : (v != 0 && !mr && stall < 65535) ? stall + 1 : stall;
      void'(pipe.pop_front());
      pipe.push_back(hs ? g : -1);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
